// File: rtl/issue_sched_if.sv
// Decode, issue and writeback bundle for issue_sched.
// The scheduler connects through the slave modport, the decode/execute side through master.
interface issue_sched_if;
    logic [1:0]   in_vld;
    logic [137:0] in_data;
    logic         in_rdy;
    logic [5:0]   unit_rdy;
    logic [5:0]   iss_vld;
    logic [413:0] iss_data;
    logic [1:0]   wb_vld;
    logic [11:0]  wb_reg;
    logic         flush;
    logic [63:0]  board;
    logic         busy;

    modport master (
        output in_vld, in_data, unit_rdy, wb_vld, wb_reg, flush,
        input  in_rdy, iss_vld, iss_data, board, busy
    );

    modport slave (
        input  in_vld, in_data, unit_rdy, wb_vld, wb_reg, flush,
        output in_rdy, iss_vld, iss_data, board, busy
    );
endinterface

// File: rtl/issue_sched.sv
// Issue scheduler: an age-ordered wait window with a register scoreboard.
// Entries issue out of order when they are free of hazards. Each issued entry
// goes to the lowest-numbered ready unit its mod field allows.
module issue_sched #(
    parameter int unsigned DEPTH = 3
) (
    input logic          clk,
    input logic          rstn,
    issue_sched_if.slave bus
);
    localparam int unsigned PW = 69;
    localparam int unsigned NU = 6;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned KW = CW + 1;
    localparam int unsigned IW = $clog2(DEPTH);

    typedef logic [PW-1:0] pkt_t;

    // Registers 0 and 32 are hardwired: they never pend and never create ordering hazards.
    function automatic logic reg_zero(input logic [5:0] r);
        return r[4:0] == 5'd0;
    endfunction

    function automatic logic pending(input logic [63:0] b, input logic [5:0] r);
        return b[r] && !reg_zero(r);
    endfunction

    // True when older packet o must hold back younger packet y.
    function automatic logic hazard(input pkt_t o, input pkt_t y);
        logic raw;
        logic war;
        logic mem;
        raw = !reg_zero(o[36:31]) && (o[36:31] == y[48:43] || o[36:31] == y[42:37]);
        war = !reg_zero(y[36:31]) &&
              (o[48:43] == y[36:31] || o[42:37] == y[36:31] || o[36:31] == y[36:31]);
        mem = (|o[1:0]) && (|y[1:0]);
        return raw || war || mem;
    endfunction

    logic [DEPTH-1:0] vld_q, vld_d;
    pkt_t             pkt_q [DEPTH];
    pkt_t             pkt_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [63:0]      board_q, board_d;
    logic [NU-1:0]    iss_vld_q, iss_vld_d;
    pkt_t             iss_pkt_q [NU];
    pkt_t             iss_pkt_d [NU];
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] issue;
    logic             in_rdy;

    // The window takes a pair only when two slots are free before this cycle's issue.
    assign in_rdy = (DEPTH - 32'(count_q)) >= 32'd2;

    // Eligibility: scoreboard clear and no hazard against any older entry valid this cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            elig[i] = vld_q[i] &&
                      !pending(board_q, pkt_q[i][48:43]) &&
                      !pending(board_q, pkt_q[i][42:37]) &&
                      !pending(board_q, pkt_q[i][36:31]);
            for (int j = 0; j < i; j++) begin
                if (vld_q[j] && hazard(pkt_q[j], pkt_q[i])) begin
                    elig[i] = 1'b0;
                end
            end
        end
    end

    // Unit allocation, oldest first; each entry takes the lowest free unit it may use.
    always_comb begin
        logic [NU-1:0] avail;
        logic          found;
        avail     = '0;
        found     = 1'b0;
        issue     = '0;
        iss_vld_d = '0;
        for (int k = 0; k < int'(NU); k++) begin
            iss_pkt_d[k] = iss_pkt_q[k];
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            avail = pkt_q[i][NU-1:0] & bus.unit_rdy & ~iss_vld_d;
            found = 1'b0;
            if (elig[i] && !bus.flush) begin
                for (int k = 0; k < int'(NU); k++) begin
                    if (!found && avail[k]) begin
                        found        = 1'b1;
                        issue[i]     = 1'b1;
                        iss_vld_d[k] = 1'b1;
                        iss_pkt_d[k] = pkt_q[i];
                    end
                end
            end
        end
    end

    // Scoreboard: writebacks clear first so that a same-edge issue set wins.
    always_comb begin
        board_d = board_q;
        for (int p = 0; p < 2; p++) begin
            if (bus.wb_vld[p]) begin
                board_d[bus.wb_reg[6*p +: 6]] = 1'b0;
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (issue[i] && !reg_zero(pkt_q[i][36:31])) begin
                board_d[pkt_q[i][36:31]] = 1'b1;
            end
        end
    end

    // Window update: compact survivors toward index 0, then append accepted slots.
    always_comb begin
        logic [KW-1:0] k;
        pkt_t          slot;
        k     = '0;
        slot  = '0;
        vld_d = '0;
        for (int t = 0; t < int'(DEPTH); t++) begin
            pkt_d[t] = '0;
        end
        if (!bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (vld_q[i] && !issue[i]) begin
                    if (k < KW'(DEPTH)) begin
                        vld_d[k[IW-1:0]] = 1'b1;
                        pkt_d[k[IW-1:0]] = pkt_q[i];
                    end
                    k = k + KW'(1);
                end
            end
            if (in_rdy) begin
                for (int s = 0; s < 2; s++) begin
                    slot = bus.in_data[PW*s +: PW];
                    // A slot with an empty unit mask carries nothing to execute.
                    if (bus.in_vld[s] && (|slot[5:0])) begin
                        if (k < KW'(DEPTH)) begin
                            vld_d[k[IW-1:0]] = 1'b1;
                            pkt_d[k[IW-1:0]] = slot;
                        end
                        k = k + KW'(1);
                    end
                end
            end
        end
        count_d = k[CW-1:0];
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q     <= '0;
            count_q   <= '0;
            board_q   <= '0;
            iss_vld_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pkt_q[i] <= '0;
            end
            for (int k = 0; k < int'(NU); k++) begin
                iss_pkt_q[k] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            count_q   <= count_d;
            board_q   <= board_d;
            iss_vld_q <= iss_vld_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pkt_q[i] <= pkt_d[i];
            end
            for (int k = 0; k < int'(NU); k++) begin
                iss_pkt_q[k] <= iss_pkt_d[k];
            end
        end
    end

    // Pack the per-unit issue registers onto the output bus.
    always_comb begin
        bus.iss_data = '0;
        for (int k = 0; k < int'(NU); k++) begin
            bus.iss_data[PW*k +: PW] = iss_pkt_q[k];
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.iss_vld = iss_vld_q;
    assign bus.board   = board_q;
    assign bus.busy    = count_q != '0;
endmodule

// File: doc/issue_sched.md
ISSUE_SCHED -- requirements
Module: issue_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3, range 2..8, giving the number of wait-window entries.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_vld, input, 2 bits: decode slot valid bits (slot 0 is older).
REQ-005 The block SHALL have port in_data, input, 138 bits: two 69-bit packets, slot 0 in [68:0].
- Packet fields: pc[68:55], ope[54:49], ds[48:43], dt[42:37], dd[36:31], imm[30:15], opr[14:10], ctrl[9:6], mod[5:0].
REQ-006 The block SHALL have port in_rdy, output, 1 bit: the window accepts both slots this cycle.
REQ-007 The block SHALL have port unit_rdy, input, 6 bits: per-unit ready.
- Bit order: io, mem, alu, alu2, fpu, fpu2 (bit 0 = io).
REQ-008 The block SHALL have port iss_vld, output, 6 bits: registered per-unit issue strobe.
REQ-009 The block SHALL have port iss_data, output, 414 bits: registered packet for unit k in [69k+68:69k].
REQ-010 The block SHALL have port wb_vld, input, 2 bits: writeback completion strobes.
REQ-011 The block SHALL have port wb_reg, input, 12 bits: writeback register numbers, port p in [6p+5:6p].
REQ-012 The block SHALL have port flush, input, 1 bit: control-hazard kill of the window.
REQ-013 The block SHALL have port board, output, 64 bits: scoreboard, bit r set means register r is pending.
- Register numbering: {fpr,gpr}, so bits 0..31 are gpr and bits 32..63 are fpr.
REQ-014 The block SHALL have port busy, output, 1 bit: the window is non-empty.

Function
REQ-015 The block SHALL drive in_rdy = (DEPTH - count) >= 2, where count is the registered number of valid entries, evaluated before this cycle's issue.
REQ-016 When in_rdy=1 and flush=0, each slot with in_vld=1 and mod!=0 SHALL be appended at the young end in slot order; a slot with mod=0 SHALL be dropped.
REQ-017 Entries SHALL stay in age order, index 0 oldest; remaining entries SHALL compact toward index 0 every cycle.
REQ-018 An entry SHALL be eligible only when all of the following hold:
- its ds, dt and dd bits are clear in board, with bits 0 and 32 always treated as clear;
- no older valid entry has a dd equal to this entry's ds or dt (RAW), or a ds, dt or dd equal to this entry's dd (WAR/WAW), register 0 and register 32 excluded;
- if the entry's mod includes io or mem, no older entry has mod including io or mem.
REQ-019 The older-entry check SHALL use all entries valid at the start of the cycle, including entries that issue in that same cycle.
REQ-020 Unit selection SHALL scan entries oldest first and give each eligible entry the lowest-numbered unit in mod & unit_rdy not already taken this cycle; an entry with no free unit SHALL wait.
REQ-021 Issue SHALL set iss_vld[k] high for exactly one cycle, with iss_data for that unit, at the edge after the decision cycle; units SHALL accept unconditionally.
REQ-022 iss_data SHALL hold its last value when iss_vld is low.
REQ-023 At issue, board[dd] SHALL be set at the same edge as iss_vld, except for dd = 0 or 32.
REQ-024 Each wb_vld[p] SHALL clear board[wb_reg[p]] at the next edge.
- If the same bit is both set by an issue and cleared by a writeback at one edge, set SHALL win.
- A writeback to an already-clear bit SHALL be ignored.
REQ-025 When flush=1, all entries SHALL be invalidated at the next edge, with no issue and no acceptance that cycle.
- board SHALL be unaffected by flush, and wb clears SHALL still apply.
REQ-026 The minimum latency SHALL be two edges: a packet accepted at edge N becomes an entry at N, is decided in cycle N..N+1, and appears on iss_vld at N+1.
REQ-027 busy SHALL equal (count != 0); count SHALL never exceed DEPTH.

Reset
REQ-028 While rstn=0, the block SHALL asynchronously clear all entries, count, board, iss_vld and iss_data to 0.
- Resulting outputs: in_rdy=1, busy=0.
REQ-029 A reset asserted mid-operation SHALL discard pending entries without emitting any issue.
REQ-030 The first acceptance SHALL occur at the first rising edge after rstn deasserts.

Verification
REQ-031 Independent ALU ops (dd=1, dd=2), all units ready:
- stimulus: both slots valid;
- response: next cycle window has 2 entries; following edge iss_vld=000100 for slot 0 and 001000 for slot 1, board=0x6.
REQ-032 RAW dependency (slot 0 dd=3, slot 1 ds=3):
- response: slot 1 waits while board[3]=1;
- stimulus: wb_vld=01, wb_reg=3;
- response: slot 1 issues on the edge after board[3] clears.
REQ-033 Two mem ops with unit_rdy mem=0 for 4 cycles:
- response: neither issues, busy=1, in_rdy=0 at count 2 with DEPTH=3;
- after mem becomes ready: issue is in order, one per cycle.
REQ-034 flush=1 with 3 entries and board=0x8:
- response: next cycle busy=0, iss_vld=0, board=0x8.
REQ-035 Writeback and new issue of the same register at one edge:
- stimulus: wb_reg=5 in the same cycle an entry with dd=5 issues;
- response: board[5]=1.
REQ-036 Writes to register 0 or 32:
- stimulus: entry with dd=0 and an entry with dd=32;
- response: both issue without board change; rstn pulse mid-stream clears all outputs immediately.
